// File: rtl/mem_dump_tx.sv
// mem_dump_tx: streams DEPTH 32-bit SRAM words out of a UART 8N1 transmitter,
// little-endian byte order, back to back.
// Optional feature: define MEM_DUMP_CHECKSUM_EN to append a modulo-256 sum of
// all data bytes as one extra byte after the last word.
module mem_dump_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 1024
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    input  logic [31:0]              mem_data,
    output logic                     tx_pin
);

    localparam int unsigned CPB = (CLKS_PER_BIT < 1) ? 32'd1 : 32'(CLKS_PER_BIT);
    localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned AW  = $clog2(DEPTH);

    localparam logic [CW-1:0] LAST_CNT  = CW'(CPB - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] LATCH     = 3'd2;
    localparam logic [2:0] START_BIT = 3'd3;
    localparam logic [2:0] DATA_BITS = 3'd4;
    localparam logic [2:0] STOP_BIT  = 3'd5;
    localparam logic [2:0] NEXT      = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   buf_q, buf_d;
    logic [AW-1:0] addr_d;
    logic [7:0]    byte_val;
    logic          tx_d, busy_d, done_d, rd_en_d;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
    logic          csum_ph_q, csum_ph_d;
    logic [7:0]    cur_q;
`endif

    // Next-state and next-output logic; outputs are registered from the next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        buf_d     = buf_q;
        addr_d    = mem_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_d    = csum_q;
        csum_ph_d = csum_ph_q;
        cur_q     = buf_q[{byte_q, 3'b000} +: 8];
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = FETCH;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_d    = 8'd0;
                    csum_ph_d = 1'b0;
`endif
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                buf_d   = mem_data;
                byte_d  = 2'd0;
                cnt_d   = '0;
                state_d = START_BIT;
            end
            START_BIT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA_BITS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA_BITS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = STOP_BIT;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP_BIT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                    if (csum_ph_q) begin
                        state_d = NEXT;
                    end else begin
                        csum_d = csum_q + cur_q;
`endif
                        if (byte_q != 2'd3) begin
                            byte_d  = byte_q + 2'd1;
                            state_d = START_BIT;
                        end else if (mem_addr != LAST_ADDR) begin
                            addr_d  = mem_addr + AW'(1);
                            state_d = FETCH;
                        end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
                            csum_ph_d = 1'b1;
                            state_d   = START_BIT;
`else
                            state_d = NEXT;
`endif
                        end
`ifdef MEM_DUMP_CHECKSUM_EN
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NEXT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        byte_val = buf_d[{byte_d, 3'b000} +: 8];
`ifdef MEM_DUMP_CHECKSUM_EN
        if (csum_ph_d) byte_val = csum_d;
`endif
        case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = byte_val[bit_d];
            default:   tx_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        rd_en_d = (state_d == FETCH);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            buf_q     <= 32'd0;
            mem_addr  <= '0;
            tx_pin    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q    <= 8'd0;
            csum_ph_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            buf_q     <= buf_d;
            mem_addr  <= addr_d;
            tx_pin    <= tx_d;
            busy      <= busy_d;
            done      <= done_d;
            mem_rd_en <= rd_en_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q    <= csum_d;
            csum_ph_q <= csum_ph_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb_mem_dump_tx: scoreboard bench for mem_dump_tx (small 2-word instance with
// UART decoding, plus a 1024-word instance for address/timing sweep).
module tb_mem_dump_tx;

    localparam int A_CPB = 4;
    localparam int A_DEPTH = 2;
    localparam int B_CPB = 1;
    localparam int B_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        nRST;
    logic        start_a, busy_a, done_a, rd_en_a, tx_a;
    logic [0:0]  addr_a;
    logic [31:0] mem_data_a;
    logic        start_b, busy_b, done_b, rd_en_b, tx_b;
    logic [9:0]  addr_b;
    logic [31:0] mem_data_b;
    logic [31:0] mem_a [0:1];

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] sb[$];
    bit         rst_hit;

    always #5 clk = ~clk;

    mem_dump_tx #(.CLKS_PER_BIT(A_CPB), .DEPTH(A_DEPTH)) dut_a (
        .clk(clk), .nRST(nRST), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_data(mem_data_a), .tx_pin(tx_a)
    );

    mem_dump_tx #(.CLKS_PER_BIT(B_CPB), .DEPTH(B_DEPTH)) dut_b (
        .clk(clk), .nRST(nRST), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_data(mem_data_b), .tx_pin(tx_b)
    );

    // Synchronous SRAM models: data one cycle after read enable
    always @(posedge clk) begin
        if (rd_en_a) mem_data_a <= mem_a[addr_a];
        if (rd_en_b) mem_data_b <= {22'h0, addr_b} ^ 32'hA5A5_0000;
    end

    task automatic wait_neg(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (!nRST) rst_hit = 1'b1;
        end
    endtask

    // UART receiver on dut_a: samples mid-bit, pops and compares scoreboard
    initial begin : uart_mon
        logic [7:0] rx;
        logic [7:0] exp_b;
        logic       st, sp, prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (nRST && prev && !tx_a) begin
                rst_hit = 1'b0;
                wait_neg(2);
                st = tx_a;
                for (int k = 0; k < 8; k++) begin
                    wait_neg(A_CPB);
                    rx[k] = tx_a;
                end
                wait_neg(A_CPB);
                sp = tx_a;
                if (!rst_hit) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL uart_byte: got %h (start=%b stop=%b), expected no byte", rx, st, sp);
                    end else begin
                        exp_b = sb.pop_front();
                        if ({st, rx, sp} !== {1'b0, exp_b, 1'b1}) begin
                            n_fail++;
                            $display("FAIL uart_byte: got %h (start=%b stop=%b), expected %h framed 0..1", rx, st, sp, exp_b);
                        end
                    end
                end
            end
            prev = tx_a;
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] csum_a();
        logic [7:0] cs = 8'd0;
        for (int w = 0; w < A_DEPTH; w++)
            for (int b = 0; b < 4; b++) cs = cs + mem_a[w][8*b +: 8];
        return cs;
    endfunction

    task automatic push_bytes();
        for (int w = 0; w < A_DEPTH; w++)
            for (int b = 0; b < 4; b++) sb.push_back(mem_a[w][8*b +: 8]);
`ifdef MEM_DUMP_CHECKSUM_EN
        sb.push_back(csum_a());
`endif
    endtask

    task automatic push_frame(inout bit q[$], input logic [7:0] v);
        for (int i = 0; i < A_CPB; i++) q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < A_CPB; i++) q.push_back(v[k]);
        for (int i = 0; i < A_CPB; i++) q.push_back(1'b1);
    endtask

    task automatic drain_sb();
        for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d bytes never received, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_a !== 1'b1)   begin n_fail++; $display("FAIL rst_tx_a: got %b, expected 1", tx_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy_a: got %b, expected 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done_a: got %b, expected 0", done_a); end
        n_checks++; if (rd_en_a !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en_a: got %b, expected 0", rd_en_a); end
        n_checks++; if (addr_a !== 1'b0) begin n_fail++; $display("FAIL rst_addr_a: got %h, expected 0", addr_a); end
        n_checks++; if (tx_b !== 1'b1)   begin n_fail++; $display("FAIL rst_tx_b: got %b, expected 1", tx_b); end
        n_checks++; if (addr_b !== 10'd0) begin n_fail++; $display("FAIL rst_addr_b: got %h, expected 0", addr_b); end
        nRST = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Full dump on dut_a: cycle-exact tx waveform, done/busy/rd_en timing, byte scoreboard
    task automatic test_dump();
        bit exp[$];
        bit wave[$];
        int first_low = 0, done_cnt = 0, done_cyc = 0, busy_cyc = 0, rd_cnt = 0;
        int wave_err = 0, exp_done;
        push_bytes();
        exp.push_back(1'b1); exp.push_back(1'b1);
        for (int w = 0; w < A_DEPTH; w++) begin
            if (w > 0) begin exp.push_back(1'b1); exp.push_back(1'b1); end
            for (int b = 0; b < 4; b++) push_frame(exp, mem_a[w][8*b +: 8]);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        push_frame(exp, csum_a());
`endif
        exp.push_back(1'b1); exp.push_back(1'b1);
        exp_done = exp.size();
        for (int i = 0; i < 10; i++) exp.push_back(1'b1);

        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int c = 1; c <= exp.size(); c++) begin
            wave.push_back(tx_a);
            if (tx_a !== exp[c-1]) wave_err++;
            if (!tx_a && first_low == 0) first_low = c;
            if (done_a) begin done_cnt++; done_cyc = c; end
            if (busy_a) busy_cyc++;
            if (rd_en_a) rd_cnt++;
            @(negedge clk);
        end
        n_checks++; if (first_low != 3) begin n_fail++; $display("FAIL first_low: got cycle %0d, expected 3", first_low); end
        n_checks++; if (wave_err != 0) begin n_fail++; $display("FAIL tx_waveform: %0d cycles differ, expected 0", wave_err); end
        n_checks++; if (wave[42] !== 1'b0) begin n_fail++; $display("FAIL gap_11_22: tx at cycle 43 got %b, expected 0", wave[42]); end
        n_checks++; if ({wave[162], wave[163], wave[164]} !== 3'b110) begin
            n_fail++; $display("FAIL gap_44_55: cycles 163..165 got %b%b%b, expected 110", wave[162], wave[163], wave[164]);
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL done_count: got %0d, expected 1", done_cnt); end
        n_checks++; if (done_cyc != exp_done) begin n_fail++; $display("FAIL done_cycle: got %0d, expected %0d", done_cyc, exp_done); end
        n_checks++; if (busy_cyc != exp_done) begin n_fail++; $display("FAIL busy_cycles: got %0d, expected %0d", busy_cyc, exp_done); end
        n_checks++; if (rd_cnt != A_DEPTH) begin n_fail++; $display("FAIL rd_en_count: got %0d, expected %0d", rd_cnt, A_DEPTH); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_end: got %b, expected 0", busy_a); end
        drain_sb();
    endtask

    // start held high through the whole dump and the DONE cycle
    task automatic test_start_held();
        int addrs[$];
        int done_cnt = 0, busy_after = 0;
        bit seen = 1'b0;
        push_bytes();
        @(negedge clk); start_a = 1'b1;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (rd_en_a) addrs.push_back(int'(addr_a));
            if (done_a) begin done_cnt++; seen = 1'b1; end
        end
        @(negedge clk);
        start_a = 1'b0;
        if (busy_a) busy_after++;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rd_en_a) addrs.push_back(int'(addr_a));
            if (done_a) done_cnt++;
            if (busy_a) busy_after++;
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL held_done: got %0d pulses, expected 1", done_cnt); end
        n_checks++; if (addrs.size() != 2) begin n_fail++; $display("FAIL held_reads: got %0d reads, expected 2", addrs.size()); end
        else begin
            n_checks++; if (addrs[0] != 0 || addrs[1] != 1) begin
                n_fail++; $display("FAIL held_addrs: got %0d,%0d, expected 0,1", addrs[0], addrs[1]);
            end
        end
        n_checks++; if (busy_after != 0) begin n_fail++; $display("FAIL held_restart: busy for %0d cycles after done, expected 0", busy_after); end
        drain_sb();
    endtask

    // Reset during data bit 3 of byte 22, then a clean dump
    task automatic test_reset_mid();
        push_bytes();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (59) @(negedge clk);
        n_checks++; if (tx_a !== 1'b0) begin n_fail++; $display("FAIL pre_abort_tx: got %b, expected 0", tx_a); end
        nRST = 1'b0;
        #1;
        n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL abort_tx: got %b, expected 1", tx_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, expected 0", busy_a); end
        sb.delete();
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_idle: busy=%b tx=%b, expected busy=0 tx=1", busy_a, tx_a);
        end
        test_dump();
    endtask

    // 1024 words at one clock per bit: address sequence, no wrap, total busy time
    task automatic test_long();
        int exp_addr = 0, addr_err = 0, rd_cnt = 0, busy_cnt = 0, exp_busy;
        bit seen = 1'b0;
        logic [9:0] addr_at_done = '0;
        exp_busy = B_DEPTH * 42 + 3;
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_busy = exp_busy + 10 * B_CPB;
`endif
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int c = 0; c < 50000 && !seen; c++) begin
            if (busy_b) busy_cnt++;
            if (rd_en_b) begin
                if (int'(addr_b) != exp_addr) addr_err++;
                exp_addr++;
                rd_cnt++;
            end
            if (done_b) begin seen = 1'b1; addr_at_done = addr_b; end
            @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL long_done: got no done within budget, expected done"); end
        n_checks++; if (rd_cnt != B_DEPTH) begin n_fail++; $display("FAIL long_reads: got %0d, expected %0d", rd_cnt, B_DEPTH); end
        n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL long_addr_seq: %0d out-of-order reads, expected 0", addr_err); end
        n_checks++; if (addr_at_done !== 10'd1023) begin n_fail++; $display("FAIL long_no_wrap: addr at done %0d, expected 1023", addr_at_done); end
        n_checks++; if (busy_cnt < exp_busy - 1 || busy_cnt > exp_busy + 1) begin
            n_fail++; $display("FAIL long_busy: got %0d cycles, expected %0d +/-1", busy_cnt, exp_busy);
        end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL long_busy_end: got %b, expected 0", busy_b); end
    endtask

    initial begin
        mem_a[0] = 32'h4433_2211;
        mem_a[1] = 32'h8877_6655;
        test_reset();
        test_dump();
        test_start_held();
        test_reset_mid();
        test_long();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
